// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle control sequencer.
// States, instruction classes, opcode/funct constants and the datapath
// control encodings (ALUOp, RegDst, MemToReg, ExtOp).
package mc_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXE    = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_JALR   = 6'b001001;
  localparam logic [5:0] FN_ADDU   = 6'b100001;
  localparam logic [5:0] FN_SUBU   = 6'b100011;
  localparam logic [5:0] FN_SLT    = 6'b101010;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_FUNCT = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;

  localparam logic [1:0] RD_RT     = 2'b00;
  localparam logic [1:0] RD_RD     = 2'b01;
  localparam logic [1:0] RD_RA     = 2'b10;

  localparam logic [1:0] M2R_ALU   = 2'b00;
  localparam logic [1:0] M2R_MEM   = 2'b01;
  localparam logic [1:0] M2R_PC4   = 2'b10;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;

  typedef enum logic [3:0] {
    CLS_ILL   = 4'd0,
    CLS_ALU_R = 4'd1,
    CLS_ALU_I = 4'd2,
    CLS_LW    = 4'd3,
    CLS_SW    = 4'd4,
    CLS_BR    = 4'd5,
    CLS_JR    = 4'd6,
    CLS_J     = 4'd7,
    CLS_JAL   = 4'd8
  } cls_e;

  // Decoded instruction: class, link flag (jalr) and the held ALU/Ext fields.
  typedef struct packed {
    cls_e       cls;
    logic       link;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
  } dec_t;

  localparam dec_t DEC_NONE = '{cls: CLS_ILL, link: 1'b0, alu_src: 1'b0,
                                alu_op: ALU_ADD, ext_op: EXT_ZERO};

  // Classes whose last cycle is DECODE (PC written there).
  function automatic logic ends_in_decode(input cls_e c);
    return (c == CLS_J) || (c == CLS_JAL) || (c == CLS_ILL);
  endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if: IR fields and memory acknowledge in, datapath strobes out.
// slave = controller side, master = datapath/testbench side.
interface mc_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic [4:0] Rt;
  logic       Ack;
  logic       MemReq;
  logic       MemWr;
  logic       IRWr;
  logic       PCWr;
  logic       Branch;
  logic       Jump;
  logic       RegWr;
  logic [1:0] RegDst;
  logic [1:0] MemToReg;
  logic       ALUSrc;
  logic [2:0] ALUOp;
  logic [1:0] ExtOp;
  logic [2:0] State;
  logic       InstrDone;
  logic       IllegalOp;

  modport slave (
    input  Op, Funct, Rt, Ack,
    output MemReq, MemWr, IRWr, PCWr, Branch, Jump, RegWr, RegDst, MemToReg,
           ALUSrc, ALUOp, ExtOp, State, InstrDone, IllegalOp
  );

  modport master (
    output Op, Funct, Rt, Ack,
    input  MemReq, MemWr, IRWr, PCWr, Branch, Jump, RegWr, RegDst, MemToReg,
           ALUSrc, ALUOp, ExtOp, State, InstrDone, IllegalOp
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational Op/Funct/Rt -> instruction class plus the
// ALU operand/op and immediate-extension fields used from EXE onward.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output dec_t       dec
);

  // Classify the instruction; anything unrecognised falls through to ILL.
  always_comb begin
    dec = DEC_NONE;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_SLT: begin
            dec.cls    = CLS_ALU_R;
            dec.alu_op = ALU_FUNCT;
          end
          FN_JR:   dec.cls = CLS_JR;
          FN_JALR: begin
            dec.cls  = CLS_JR;
            dec.link = 1'b1;
          end
          default: dec.cls = CLS_ILL;
        endcase
      end
      OP_REGIMM: begin
        if ((rt == RT_BGEZ) || (rt == RT_BLTZ)) begin
          dec.cls    = CLS_BR;
          dec.alu_op = ALU_SUB;
          dec.ext_op = EXT_SIGN;
        end else begin
          dec.cls = CLS_ILL;
        end
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        dec.cls    = CLS_BR;
        dec.alu_op = ALU_SUB;
        dec.ext_op = EXT_SIGN;
      end
      OP_ORI, OP_LUI: begin
        dec.cls     = CLS_ALU_I;
        dec.alu_src = 1'b1;
        dec.alu_op  = (op == OP_ORI) ? ALU_OR : ALU_LUI;
        dec.ext_op  = EXT_ZERO;
      end
      OP_LW, OP_SW: begin
        dec.cls     = (op == OP_LW) ? CLS_LW : CLS_SW;
        dec.alu_src = 1'b1;
        dec.alu_op  = ALU_ADD;
        dec.ext_op  = EXT_SIGN;
      end
      OP_J:    dec.cls = CLS_J;
      OP_JAL:  dec.cls = CLS_JAL;
      default: dec.cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXE/MEM/WB control sequencer.
// Optional feature: MC_CTRL_MEM_WAIT_EN makes FETCH and MEM wait for Ack.
// Outputs are combinational from the state and the class latched at
// DECODE (the live decode is used during DECODE itself), gated to 0
// while Reset is low.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  mc_if.slave  bus
);

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  dec_t       dec_s;
  dec_t       dec_r;
  dec_t       cur_s;
  logic       mem_ok_s;

  logic       mem_req_s, mem_wr_s, ir_wr_s, pc_wr_s, branch_s, jump_s, reg_wr_s;
  logic [1:0] reg_dst_s, mem_to_reg_s, ext_op_s;
  logic       alu_src_s, done_s, ill_s;
  logic [2:0] alu_op_s;

  mc_decode u_decode (
    .op    (bus.Op),
    .funct (bus.Funct),
    .rt    (bus.Rt),
    .dec   (dec_s)
  );

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_ok_s = bus.Ack;
`else
  logic ack_unused_s;
  assign ack_unused_s = bus.Ack;
  assign mem_ok_s     = 1'b1;
`endif

  assign cur_s = (state_r == ST_DECODE) ? dec_s : dec_r;

  // Next-state selection from the current state and instruction class.
  always_comb begin
    state_nxt_s = ST_FETCH;
    case (state_r)
      ST_FETCH:  state_nxt_s = mem_ok_s ? ST_DECODE : ST_FETCH;
      ST_DECODE: state_nxt_s = ends_in_decode(cur_s.cls) ? ST_FETCH : ST_EXE;
      ST_EXE: begin
        case (cur_s.cls)
          CLS_BR, CLS_JR: state_nxt_s = ST_FETCH;
          CLS_LW, CLS_SW: state_nxt_s = ST_MEM;
          default:        state_nxt_s = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (!mem_ok_s) begin
          state_nxt_s = ST_MEM;
        end else begin
          state_nxt_s = (cur_s.cls == CLS_SW) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB:   state_nxt_s = ST_FETCH;
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // State register and class latch (captured on leaving DECODE).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_FETCH;
      dec_r   <= DEC_NONE;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_DECODE) begin
        dec_r <= dec_s;
      end else begin
        dec_r <= dec_r;
      end
    end
  end

  // Per-state strobe decode; ALU controls held through EXE, MEM and WB.
  always_comb begin
    mem_req_s = 1'b0; mem_wr_s = 1'b0; ir_wr_s = 1'b0; pc_wr_s = 1'b0;
    branch_s = 1'b0; jump_s = 1'b0; reg_wr_s = 1'b0;
    reg_dst_s = RD_RT; mem_to_reg_s = M2R_ALU;
    alu_src_s = 1'b0; alu_op_s = ALU_ADD; ext_op_s = EXT_ZERO;
    done_s = 1'b0; ill_s = 1'b0;
    if ((state_r == ST_EXE) || (state_r == ST_MEM) || (state_r == ST_WB)) begin
      alu_src_s = cur_s.alu_src;
      alu_op_s  = cur_s.alu_op;
      ext_op_s  = cur_s.ext_op;
    end else begin
      alu_src_s = 1'b0;
    end
    case (state_r)
      ST_FETCH: begin
        mem_req_s = 1'b1;
        ir_wr_s   = mem_ok_s;
      end
      ST_DECODE: begin
        case (cur_s.cls)
          CLS_J: begin
            jump_s = 1'b1; pc_wr_s = 1'b1; done_s = 1'b1;
          end
          CLS_JAL: begin
            jump_s = 1'b1; pc_wr_s = 1'b1; done_s = 1'b1;
            reg_wr_s = 1'b1; reg_dst_s = RD_RA; mem_to_reg_s = M2R_PC4;
          end
          CLS_ILL: begin
            pc_wr_s = 1'b1; ill_s = 1'b1; done_s = 1'b1;
          end
          default: done_s = 1'b0;
        endcase
      end
      ST_EXE: begin
        case (cur_s.cls)
          CLS_BR: begin
            branch_s = 1'b1; pc_wr_s = 1'b1; done_s = 1'b1;
          end
          CLS_JR: begin
            jump_s = 1'b1; pc_wr_s = 1'b1; done_s = 1'b1;
            if (cur_s.link) begin
              reg_wr_s = 1'b1; reg_dst_s = RD_RD; mem_to_reg_s = M2R_PC4;
            end else begin
              reg_wr_s = 1'b0;
            end
          end
          default: done_s = 1'b0;
        endcase
      end
      ST_MEM: begin
        mem_req_s = 1'b1;
        if (cur_s.cls == CLS_SW) begin
          mem_wr_s = 1'b1; pc_wr_s = mem_ok_s; done_s = mem_ok_s;
        end else begin
          mem_wr_s = 1'b0;
        end
      end
      ST_WB: begin
        reg_wr_s = 1'b1; pc_wr_s = 1'b1; done_s = 1'b1;
        case (cur_s.cls)
          CLS_LW: begin
            mem_to_reg_s = M2R_MEM; reg_dst_s = RD_RT;
          end
          CLS_ALU_R: reg_dst_s = RD_RD;
          default:   reg_dst_s = RD_RT;
        endcase
      end
      default: done_s = 1'b0;
    endcase
  end

  assign bus.MemReq    = mem_req_s & Reset;
  assign bus.MemWr     = mem_wr_s & Reset;
  assign bus.IRWr      = ir_wr_s & Reset;
  assign bus.PCWr      = pc_wr_s & Reset;
  assign bus.Branch    = branch_s & Reset;
  assign bus.Jump      = jump_s & Reset;
  assign bus.RegWr     = reg_wr_s & Reset;
  assign bus.RegDst    = reg_dst_s & {2{Reset}};
  assign bus.MemToReg  = mem_to_reg_s & {2{Reset}};
  assign bus.ALUSrc    = alu_src_s & Reset;
  assign bus.ALUOp     = alu_op_s & {3{Reset}};
  assign bus.ExtOp     = ext_op_s & {2{Reset}};
  assign bus.State     = state_r & {3{Reset}};
  assign bus.InstrDone = done_s & Reset;
  assign bus.IllegalOp = ill_s & Reset;

endmodule
